// File: rtl/hazard_ctrl_md.sv
// Hazard controller for the F/D/E/M/W pipeline: Tuse/Tnew data stalls,
// forwarding selects, an internal multiply/divide busy timer and a
// saturating stall-cycle counter. FWD_EN=0 gives a stall-only variant.
module hazard_ctrl_md #(
    parameter int AW       = 5,
    parameter int TW       = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    A1D,
    input  logic [AW-1:0]    A2D,
    input  logic [AW-1:0]    A1E,
    input  logic [AW-1:0]    A2E,
    input  logic [AW-1:0]    A2M,
    input  logic [AW-1:0]    A3E,
    input  logic [AW-1:0]    A3M,
    input  logic [AW-1:0]    A3W,
    input  logic [TW-1:0]    rsTuse,
    input  logic [TW-1:0]    rtTuse,
    input  logic [TW-1:0]    TnewE,
    input  logic [TW-1:0]    TnewM,
    input  logic             RFenE,
    input  logic             RFenM,
    input  logic             RFenW,
    input  logic [1:0]       mdOpD,
    input  logic [1:0]       mdOpE,
    output logic [1:0]       RD1DSel,
    output logic [1:0]       RD2DSel,
    output logic [1:0]       RD1ESel,
    output logic [1:0]       RD2ESel,
    output logic             DMWDSel,
    output logic             stallPC,
    output logic             stallD,
    output logic             clrE,
    output logic [1:0]       stallCause,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;
    localparam logic [TMR_W-1:0] MULT_LD = TMR_W'(MULT_CYC);
    localparam logic [TMR_W-1:0] DIV_LD  = TMR_W'(DIV_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_W  = 2'b01;
    localparam logic [1:0] SEL_M  = 2'b10;

    md_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic data_stall;
    logic md_stall;
    logic stall;
    logic md_busy;

    // Register 0 is hardwired zero, so it never produces a dependency.
    function automatic logic match(input logic [AW-1:0] x,
                                   input logic [AW-1:0] y,
                                   input logic          en);
        return (x == y) && (x != '0) && en;
    endfunction

    // M-stage result wins over W because it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] idx,
                                           input logic [AW-1:0] a3m,
                                           input logic          rfen_m,
                                           input logic          tnew_m_zero,
                                           input logic [AW-1:0] a3w,
                                           input logic          rfen_w);
        if (match(idx, a3m, rfen_m) && tnew_m_zero) return SEL_M;
        else if (match(idx, a3w, rfen_w))           return SEL_W;
        else                                        return SEL_RF;
    endfunction

    // Data-dependency stall detection and forwarding-mux selects.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        data_stall = 1'b0;
        RD1DSel    = SEL_RF;
        RD2DSel    = SEL_RF;
        RD1ESel    = SEL_RF;
        RD2ESel    = SEL_RF;
        DMWDSel    = 1'b0;
        if (FWD_EN != 0) begin
            data_stall = (match(A1D, A3E, RFenE) && (rsTuse < TnewE)) ||
                         (match(A1D, A3M, RFenM) && (rsTuse < TnewM)) ||
                         (match(A2D, A3E, RFenE) && (rtTuse < TnewE)) ||
                         (match(A2D, A3M, RFenM) && (rtTuse < TnewM));
            RD1DSel = fwd_sel(A1D, A3M, RFenM, TnewM == '0, A3W, RFenW);
            RD2DSel = fwd_sel(A2D, A3M, RFenM, TnewM == '0, A3W, RFenW);
            RD1ESel = fwd_sel(A1E, A3M, RFenM, TnewM == '0, A3W, RFenW);
            RD2ESel = fwd_sel(A2E, A3M, RFenM, TnewM == '0, A3W, RFenW);
            DMWDSel = match(A2M, A3W, RFenW);
        end else begin
            // Without forwarding, any in-flight writer of a D operand must
            // drain, including W, since RF write-through is not assumed.
            data_stall = match(A1D, A3E, RFenE) || match(A1D, A3M, RFenM) ||
                         match(A1D, A3W, RFenW) || match(A2D, A3E, RFenE) ||
                         match(A2D, A3M, RFenM) || match(A2D, A3W, RFenW);
        end
    end

    // MD FSM state and timer register; reset aborts any running operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // MD FSM next state: load latency on E-stage issue, count down while busy.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (mdOpE == 2'b10) begin
                    state_d = BUSY;
                    timer_d = MULT_LD;
                end else if (mdOpE == 2'b11) begin
                    state_d = BUSY;
                    timer_d = DIV_LD;
                end
            end
            BUSY: begin
                // A new issue while busy cannot happen in a stalling
                // pipeline; if it does, the newer operation's latency wins.
                if (mdOpE == 2'b10) begin
                    timer_d = MULT_LD;
                end else if (mdOpE == 2'b11) begin
                    timer_d = DIV_LD;
                end else if (timer_q == TMR_ONE) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // MD FSM outputs and the combined stall decision.
    always_comb begin
        md_busy    = (state_q == BUSY);
        md_stall   = (mdOpD != 2'b00) && (mdOpE[1] || md_busy);
        stall      = data_stall || md_stall;
        stallCause = {md_stall, data_stall};
        stallPC    = stall;
        stallD     = stall;
        clrE       = stall;
        mdBusy     = md_busy;
    end

    // Stall counter next value: increment on stalled cycles, hold at all-ones.
    always_comb begin
        count_d = count_q;
        if (stall && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stallCount = count_q;

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Self-checking bench for hazard_ctrl_md: a forwarding instance (defaults)
// and a stall-only instance with a 4-bit counter share the same stimulus.
module tb_hazard_ctrl_md;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [4:0] A1D, A2D, A1E, A2E, A2M, A3E, A3M, A3W;
    logic [2:0] rsTuse, rtTuse, TnewE, TnewM;
    logic       RFenE, RFenM, RFenW;
    logic [1:0] mdOpD, mdOpE;

    logic [1:0]  rd1d_0, rd2d_0, rd1e_0, rd2e_0, cause_0;
    logic        dmwd_0, spc_0, sd_0, clre_0, busy_0;
    logic [31:0] cnt_0;
    logic [1:0]  rd1d_1, rd2d_1, rd1e_1, rd2e_1, cause_1;
    logic        dmwd_1, spc_1, sd_1, clre_1, busy_1;
    logic [3:0]  cnt_1;

    hazard_ctrl_md u_fwd (
        .clk(clk), .reset_n(reset_n),
        .A1D(A1D), .A2D(A2D), .A1E(A1E), .A2E(A2E), .A2M(A2M),
        .A3E(A3E), .A3M(A3M), .A3W(A3W),
        .rsTuse(rsTuse), .rtTuse(rtTuse), .TnewE(TnewE), .TnewM(TnewM),
        .RFenE(RFenE), .RFenM(RFenM), .RFenW(RFenW),
        .mdOpD(mdOpD), .mdOpE(mdOpE),
        .RD1DSel(rd1d_0), .RD2DSel(rd2d_0), .RD1ESel(rd1e_0), .RD2ESel(rd2e_0),
        .DMWDSel(dmwd_0), .stallPC(spc_0), .stallD(sd_0), .clrE(clre_0),
        .stallCause(cause_0), .mdBusy(busy_0), .stallCount(cnt_0)
    );

    hazard_ctrl_md #(.FWD_EN(0), .CNT_W(4)) u_nofwd (
        .clk(clk), .reset_n(reset_n),
        .A1D(A1D), .A2D(A2D), .A1E(A1E), .A2E(A2E), .A2M(A2M),
        .A3E(A3E), .A3M(A3M), .A3W(A3W),
        .rsTuse(rsTuse), .rtTuse(rtTuse), .TnewE(TnewE), .TnewM(TnewM),
        .RFenE(RFenE), .RFenM(RFenM), .RFenW(RFenW),
        .mdOpD(mdOpD), .mdOpE(mdOpE),
        .RD1DSel(rd1d_1), .RD2DSel(rd2d_1), .RD1ESel(rd1e_1), .RD2ESel(rd2e_1),
        .DMWDSel(dmwd_1), .stallPC(spc_1), .stallD(sd_1), .clrE(clre_1),
        .stallCause(cause_1), .mdBusy(busy_1), .stallCount(cnt_1)
    );

    // Inputs, then expectations for the forwarding instance, then the
    // expected STALL of the stall-only instance. rfen is {E,M,W}.
    typedef struct {
        int a1d, a2d, a1e, a2e, a2m, a3e, a3m, a3w;
        int rs_tuse, rt_tuse, tnew_e, tnew_m;
        int rfen, md_d, md_e;
        int x_rd1d, x_rd2d, x_rd1e, x_rd2e, x_dmwd, x_cause, x_stall1;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        A1D = '0; A2D = '0; A1E = '0; A2E = '0; A2M = '0;
        A3E = '0; A3M = '0; A3W = '0;
        rsTuse = '0; rtTuse = '0; TnewE = '0; TnewM = '0;
        RFenE = 1'b0; RFenM = 1'b0; RFenW = 1'b0;
        mdOpD = '0; mdOpE = '0;
    endtask

    task automatic apply(input vec_t v);
        A1D = 5'(v.a1d); A2D = 5'(v.a2d); A1E = 5'(v.a1e); A2E = 5'(v.a2e);
        A2M = 5'(v.a2m); A3E = 5'(v.a3e); A3M = 5'(v.a3m); A3W = 5'(v.a3w);
        rsTuse = 3'(v.rs_tuse); rtTuse = 3'(v.rt_tuse);
        TnewE = 3'(v.tnew_e); TnewM = 3'(v.tnew_m);
        RFenE = v.rfen[2]; RFenM = v.rfen[1]; RFenW = v.rfen[0];
        mdOpD = 2'(v.md_d); mdOpE = 2'(v.md_e);
    endtask

    initial begin
        //            a1d a2d a1e a2e a2m a3e a3m a3w rs rt tE tM rfen dD dE  1D 2D 1E 2E dm ca s1
        vecs[0]  = '{ 8,  0,  0,  0,  0,  8,  0,  0,  1, 0, 2, 0, 4,   0, 0,  0, 0, 0, 0, 0, 1, 1 }; // load-use
        vecs[1]  = '{ 8,  0,  0,  0,  0,  0,  0,  0,  1, 0, 2, 0, 4,   0, 0,  0, 0, 0, 0, 0, 0, 0 }; // A3E=0
        vecs[2]  = '{ 0,  0,  5,  0,  0,  0,  5,  5,  0, 0, 0, 0, 3,   0, 0,  0, 0, 2, 0, 0, 0, 0 }; // M over W
        vecs[3]  = '{ 0,  0,  5,  0,  0,  0,  5,  5,  0, 0, 0, 1, 3,   0, 0,  0, 0, 1, 0, 0, 0, 0 }; // TnewM=1 -> W
        vecs[4]  = '{ 7,  0,  0,  0,  0,  0,  7,  0,  0, 0, 0, 0, 2,   0, 0,  2, 0, 0, 0, 0, 0, 1 }; // D fwd from M
        vecs[5]  = '{ 5,  5,  0,  0,  0,  0,  5,  5,  0, 0, 0, 0, 3,   0, 0,  2, 2, 0, 0, 0, 0, 1 }; // D M over W
        vecs[6]  = '{ 0,  9,  0,  0,  0,  0,  9,  0,  0, 1, 0, 2, 2,   0, 0,  0, 0, 0, 0, 0, 1, 1 }; // rt stall on M
        vecs[7]  = '{ 0,  9,  0,  0,  0,  9,  0,  0,  0, 1, 1, 0, 4,   0, 0,  0, 0, 0, 0, 0, 0, 1 }; // Tuse==Tnew
        vecs[8]  = '{ 4,  0,  0,  0,  0,  4,  0,  0,  0, 0, 2, 0, 0,   0, 0,  0, 0, 0, 0, 0, 0, 0 }; // RFen off
        vecs[9]  = '{ 0,  6,  0,  6,  6,  0,  0,  6,  0, 0, 0, 0, 1,   0, 0,  0, 1, 0, 1, 1, 0, 1 }; // W fwd + store
        vecs[10] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 7,   0, 0,  0, 0, 0, 0, 0, 0, 0 }; // reg 0 only
        vecs[11] = '{ 0,  3,  0,  0,  0,  0,  0,  3,  0, 0, 0, 0, 1,   0, 0,  0, 1, 0, 0, 0, 0, 1 }; // W match
        vecs[12] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0,   1, 1,  0, 0, 0, 0, 0, 0, 0 }; // HI/LO in E
        vecs[13] = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0,   2, 0,  0, 0, 0, 0, 0, 0, 0 }; // MD idle
        vecs[14] = '{ 8,  0,  0,  0,  0,  8,  0,  0,  1, 0, 2, 0, 4,   3, 2,  0, 0, 0, 0, 0, 3, 1 }; // both causes

        // Reset holds the timer off even with a mult sitting in E.
        clear_inputs();
        reset_n = 1'b0;
        mdOpE   = 2'b10;
        tick();
        tick();
        check("rst_busy", int'(busy_0), 0);
        check("rst_cnt", int'(cnt_0), 0);
        check("rst_cnt_nofwd", int'(cnt_1), 0);
        mdOpE   = 2'b00;
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", int'(busy_0), 0);
        check("post_rst_cnt", int'(cnt_0), 0);

        // Combinational vector table.
        for (int i = 0; i < NVEC; i++) begin
            tick();
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_rd1d", i), int'(rd1d_0), vecs[i].x_rd1d);
            check($sformatf("v%0d_rd2d", i), int'(rd2d_0), vecs[i].x_rd2d);
            check($sformatf("v%0d_rd1e", i), int'(rd1e_0), vecs[i].x_rd1e);
            check($sformatf("v%0d_rd2e", i), int'(rd2e_0), vecs[i].x_rd2e);
            check($sformatf("v%0d_dmwd", i), int'(dmwd_0), vecs[i].x_dmwd);
            check($sformatf("v%0d_cause", i), int'(cause_0), vecs[i].x_cause);
            check($sformatf("v%0d_stall3", i), int'({spc_0, sd_0, clre_0}),
                  (vecs[i].x_cause != 0) ? 7 : 0);
            check($sformatf("v%0d_nofwd_stall3", i), int'({spc_1, sd_1, clre_1}),
                  (vecs[i].x_stall1 != 0) ? 7 : 0);
            check($sformatf("v%0d_nofwd_sels", i),
                  int'({rd1d_1, rd2d_1, rd1e_1, rd2e_1, dmwd_1}), 0);
            check($sformatf("v%0d_busy", i), int'(busy_0), 0);
        end

        // Clear the timer the last vector started.
        tick();
        clear_inputs();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;

        // MULT issue: STALL for 1+5 cycles, mdBusy for 5.
        tick();
        mdOpE = 2'b10;
        mdOpD = 2'b01;
        #1;
        check("mult_issue_stall", int'(sd_0), 1);
        check("mult_issue_busy", int'(busy_0), 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            mdOpE = 2'b00;
            #1;
            check($sformatf("mult_c%0d_busy", c), int'(busy_0), 1);
            check($sformatf("mult_c%0d_stall", c), int'(sd_0), 1);
        end
        tick();
        #1;
        check("mult_end_busy", int'(busy_0), 0);
        check("mult_end_stall", int'(sd_0), 0);
        check("mult_cnt", int'(cnt_0), 6);
        check("mult_cnt_nofwd", int'(cnt_1), 6);

        // DIV aborted by reset in its fourth busy cycle.
        tick();
        mdOpE = 2'b11;
        mdOpD = 2'b01;
        #1;
        check("div_issue_stall", int'(sd_0), 1);
        tick();
        mdOpE = 2'b00;
        tick();
        tick();
        tick();
        check("div_c4_busy", int'(busy_0), 1);
        check("div_c4_stall", int'(sd_0), 1);
        reset_n = 1'b0;
        #1;
        check("div_rst_busy", int'(busy_0), 0);
        check("div_rst_stall", int'(sd_0), 0);
        check("div_rst_cnt", int'(cnt_0), 0);
        #1;
        reset_n = 1'b1;
        tick();
        check("div_after_busy", int'(busy_0), 0);
        check("div_after_stall", int'(sd_0), 0);
        check("div_after_cnt", int'(cnt_0), 0);

        // Stall-only instance: W match stalls and its 4-bit counter saturates.
        clear_inputs();
        A2D   = 5'd3;
        A3W   = 5'd3;
        RFenW = 1'b1;
        #1;
        check("nofwd_w_stall", int'(sd_1), 1);
        check("nofwd_w_rd2d", int'(rd2d_1), 0);
        check("fwd_w_rd2d", int'(rd2d_0), 1);
        check("fwd_w_stall", int'(sd_0), 0);
        for (int c = 0; c < 10; c++) tick();
        check("nofwd_cnt10", int'(cnt_1), 10);
        for (int c = 0; c < 10; c++) tick();
        check("nofwd_cnt_sat", int'(cnt_1), 15);
        tick();
        check("nofwd_cnt_hold", int'(cnt_1), 15);
        check("fwd_cnt_zero", int'(cnt_0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
